// File: rtl/rscl_fetch_buf.sv
// rscl_fetch_buf: instruction fetch unit with a prefetch FIFO.
// Keeps up to MAX_OUTSTANDING requests in flight on the i_a/i_d bus and queues
// returned words in a BUF_DEPTH entry FIFO. A jump flushes the FIFO and
// discards every response still owed by the bus for pre-jump requests.
module rscl_fetch_buf #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned BUF_DEPTH       = 4,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        i_a_valid,
    input  logic        i_a_ready,
    output logic [31:0] i_a_addr,
    input  logic        i_d_valid,
    output logic        i_d_ready,
    input  logic        i_d_err,
    input  logic [31:0] i_d_data,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic        fetch_err,
    input  logic        fetch_stall,
    input  logic        jump,
    input  logic [31:0] jump_pc
);

    // One counter width covers inflight, drop, FIFO count and their sum.
    localparam int unsigned CNT_W = $clog2(2 * BUF_DEPTH + 1);
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);

    // Request register
    logic             a_valid_q, a_valid_d;
    logic [31:0]      a_addr_q, a_addr_d;
    logic             a_stale_q, a_stale_d;
    logic [31:0]      pc_q, pc_d;

    // Response bookkeeping
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [31:0]      resp_pc_q, resp_pc_d;

    // FIFO
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      mem_instr_q [BUF_DEPTH];
    logic [31:0]      mem_pc_q    [BUF_DEPTH];
    logic             mem_err_q   [BUF_DEPTH];

    logic [31:0]      jump_tgt;
    logic [31:0]      pc_n;
    logic             accept, resp, keep, push, pop, hold, can_issue;

    // The low address bits of a jump target are forced to zero.
    logic             unused_jump_lsb;
    assign unused_jump_lsb = ^jump_pc[1:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Handshake events and response bookkeeping for this cycle
    always_comb begin
        jump_tgt   = {jump_pc[31:2], 2'b00};
        accept     = a_valid_q && i_a_ready;
        // A response with nothing outstanding is a bus protocol error and is ignored.
        resp       = i_d_valid && (inflight_q != '0);
        keep       = resp && (drop_q == '0);
        push       = keep && !jump;
        pop        = (count_q != '0) && !fetch_stall && !jump;
        hold       = a_valid_q && !i_a_ready;

        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(resp);

        // After a jump every response still owed belongs to the old stream,
        // including a request accepted in the jump cycle itself.
        if (jump) begin
            drop_d = inflight_d;
        end else begin
            drop_d = drop_q - CNT_W'(resp && !keep) + CNT_W'(accept && a_stale_q);
        end

        if (jump) begin
            resp_pc_d = jump_tgt;
        end else if (keep) begin
            resp_pc_d = resp_pc_q + 32'd4;
        end else begin
            resp_pc_d = resp_pc_q;
        end
    end

    // FIFO occupancy and pointers; a jump empties the queue outright
    always_comb begin
        if (jump) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        end
    end

    // Next request: hold a presented request until accepted, otherwise issue
    // when the post-cycle credit guarantees a FIFO slot for its response.
    always_comb begin
        pc_n      = jump ? jump_tgt : pc_q;
        can_issue = (inflight_d < MAX_CNT) && ((inflight_d + count_d) < DEPTH_CNT);

        if (hold) begin
            a_valid_d = 1'b1;
            a_addr_d  = a_addr_q;
            a_stale_d = a_stale_q || jump;
            pc_d      = pc_n;
        end else if (can_issue) begin
            a_valid_d = 1'b1;
            a_addr_d  = pc_n;
            a_stale_d = 1'b0;
            pc_d      = pc_n + 32'd4;
        end else begin
            a_valid_d = 1'b0;
            a_addr_d  = pc_n;
            a_stale_d = 1'b0;
            pc_d      = pc_n;
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_q  <= 1'b0;
            a_addr_q   <= RESET_PC;
            a_stale_q  <= 1'b0;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            a_valid_q  <= a_valid_d;
            a_addr_q   <= a_addr_d;
            a_stale_q  <= a_stale_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // FIFO storage; contents are only visible through a non-empty head
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr_q[wr_ptr_q] <= i_d_data;
            mem_pc_q[wr_ptr_q]    <= resp_pc_q;
            mem_err_q[wr_ptr_q]   <= i_d_err;
        end
    end

    assign i_a_valid   = a_valid_q;
    assign i_a_addr    = a_addr_q;
    assign i_d_ready   = !rst;
    assign fetch_valid = (count_q != '0);
    assign fetch_instr = fetch_valid ? mem_instr_q[rd_ptr_q] : '0;
    assign fetch_pc    = fetch_valid ? mem_pc_q[rd_ptr_q]    : '0;
    assign fetch_err   = fetch_valid ? mem_err_q[rd_ptr_q]   : 1'b0;

    // Responses must only arrive for accepted requests.
    resp_without_request: assert property (@(posedge clk) disable iff (rst)
        !(i_d_valid && (inflight_q == '0)));

endmodule
